wr_ptr_full: RTL and testbench



---
 rtl/wr_ptr_full.sv | 98 +++++++++
 tb/tb_wr_ptr_full.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module   : wr_ptr_full
// Brief    : Async-FIFO write side: binary/Gray write pointers, filtered full
//            flag, occupancy estimate, almost-full and overflow pulse.
// Revision : 1.0
// ============================================================================
module wr_ptr_full #(
  parameter int unsigned C_DEPTH_BITS   = 10,
  parameter int unsigned C_AFULL_THRESH = 1020
) (
  input  logic                    WR_CLK,
  input  logic                    WR_RST,
  input  logic                    WR_EN,
  input  logic                    CMP_FULL,
  input  logic [C_DEPTH_BITS-1:0] RD_PTR_SYNC,
  output logic                    WR_FULL,
  output logic [C_DEPTH_BITS-1:0] WR_PTR,
  output logic [C_DEPTH_BITS-1:0] WR_PTR_P1,
  output logic [C_DEPTH_BITS-1:0] WR_ADDR,
  output logic [C_DEPTH_BITS:0]   WR_COUNT,
  output logic                    WR_ALMOST_FULL,
  output logic                    WR_OVERFLOW
);

  localparam logic [C_DEPTH_BITS:0]   C_AFULL_LVL = C_AFULL_THRESH[C_DEPTH_BITS:0];
  localparam logic [C_DEPTH_BITS:0]   C_FULL_CNT  = {1'b1, {C_DEPTH_BITS{1'b0}}};
  localparam logic [C_DEPTH_BITS-1:0] C_ONE       = {{(C_DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [C_DEPTH_BITS-1:0] r_bin;
  logic [C_DEPTH_BITS-1:0] r_bin_p1;
  logic [C_DEPTH_BITS-1:0] r_ptr;
  logic [C_DEPTH_BITS-1:0] r_ptr_p1;
  logic                    r_full;
  logic                    r_full2;
  logic [C_DEPTH_BITS:0]   r_count;
  logic                    r_afull;
  logic                    r_overflow;

  logic                    w_accept;
  logic [C_DEPTH_BITS-1:0] w_inc;
  logic [C_DEPTH_BITS-1:0] w_bin_next;
  logic [C_DEPTH_BITS-1:0] w_bin_p1_next;
  logic                    w_full_next;
  logic [C_DEPTH_BITS-1:0] w_rd_bin;
  logic [C_DEPTH_BITS-1:0] w_diff;
  logic [C_DEPTH_BITS:0]   w_count_next;

  // CMP_FULL blocks the write in the same cycle, before WR_FULL can react
  assign w_accept      = WR_EN & ~r_full & ~CMP_FULL;
  assign w_inc         = w_accept ? C_ONE : '0;
  assign w_bin_next    = r_bin + w_inc;
  assign w_bin_p1_next = r_bin_p1 + w_inc;
  assign w_full_next   = CMP_FULL | r_full2;

  // Each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i < int'(C_DEPTH_BITS); i++) begin : g_g2b
    assign w_rd_bin[i] = ^(RD_PTR_SYNC >> i);
  end

  assign w_diff       = w_bin_next - w_rd_bin;
  assign w_count_next = w_full_next ? C_FULL_CNT : {1'b0, w_diff};

  always_ff @(posedge WR_CLK) begin
    if (WR_RST) begin
      r_bin      <= '0;
      r_bin_p1   <= C_ONE;
      r_ptr      <= '0;
      r_ptr_p1   <= C_ONE;
      r_full     <= 1'b0;
      r_full2    <= 1'b0;
      r_count    <= '0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_bin      <= w_bin_next;
      r_bin_p1   <= w_bin_p1_next;
      r_ptr      <= w_bin_next ^ (w_bin_next >> 1);
      r_ptr_p1   <= w_bin_p1_next ^ (w_bin_p1_next >> 1);
      // Fast set, two-cycle filtered release
      r_full     <= w_full_next;
      r_full2    <= CMP_FULL;
      r_count    <= w_count_next;
      r_afull    <= (w_count_next >= C_AFULL_LVL);
      r_overflow <= WR_EN & (r_full | CMP_FULL);
    end
  end

  assign WR_FULL        = r_full;
  assign WR_PTR         = r_ptr;
  assign WR_PTR_P1      = r_ptr_p1;
  assign WR_ADDR        = r_bin;
  assign WR_COUNT       = r_count;
  assign WR_ALMOST_FULL = r_afull;
  assign WR_OVERFLOW    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_ptr_full
// Brief    : Directed vector table plus randomized run against a reference
//            model of the write-side pointer/full block (depth 8, afull 6).
// Revision : 1.0
// ============================================================================
module tb_wr_ptr_full;

  logic       clk;
  logic       WR_RST;
  logic       WR_EN;
  logic       CMP_FULL;
  logic [2:0] RD_PTR_SYNC;
  logic       WR_FULL;
  logic [2:0] WR_PTR;
  logic [2:0] WR_PTR_P1;
  logic [2:0] WR_ADDR;
  logic [3:0] WR_COUNT;
  logic       WR_ALMOST_FULL;
  logic       WR_OVERFLOW;

  wr_ptr_full #(.C_DEPTH_BITS(3), .C_AFULL_THRESH(6)) dut (
    .WR_CLK         (clk),
    .WR_RST         (WR_RST),
    .WR_EN          (WR_EN),
    .CMP_FULL       (CMP_FULL),
    .RD_PTR_SYNC    (RD_PTR_SYNC),
    .WR_FULL        (WR_FULL),
    .WR_PTR         (WR_PTR),
    .WR_PTR_P1      (WR_PTR_P1),
    .WR_ADDR        (WR_ADDR),
    .WR_COUNT       (WR_COUNT),
    .WR_ALMOST_FULL (WR_ALMOST_FULL),
    .WR_OVERFLOW    (WR_OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: write count modulo depth, and edges since CMP_FULL was last seen high
  int m_bin = 0;
  int m_age = 99;
  int m_ov  = 0;
  int m_cnt = 0;

  typedef struct {
    int rst, en, cmp, rd;
    int addr, ptr, p1, full, cnt, af, ov;
  } vec_t;

  vec_t tbl[25];

  function automatic int gray(input int x);
    return (x ^ (x >> 1)) & 7;
  endfunction

  function automatic int ungray(input int g);
    for (int v = 0; v < 8; v++)
      if (gray(v) == g) return v;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input int rst, input int en, input int cmp, input int rd);
    bit full_now;
    bit acc;
    WR_RST      = rst[0];
    WR_EN       = en[0];
    CMP_FULL    = cmp[0];
    RD_PTR_SYNC = rd[2:0];
    @(posedge clk);
    if (rst != 0) begin
      m_bin = 0;
      m_age = 99;
      m_ov  = 0;
      m_cnt = 0;
    end else begin
      full_now = (m_age <= 1);
      acc      = (en != 0) && !full_now && (cmp == 0);
      m_ov     = ((en != 0) && (full_now || cmp != 0)) ? 1 : 0;
      if (acc) m_bin = (m_bin + 1) % 8;
      m_age    = (cmp != 0) ? 0 : ((m_age >= 99) ? 99 : m_age + 1);
      m_cnt    = (m_age <= 1) ? 8 : (m_bin - ungray(rd) + 8) % 8;
    end
    #1;
    chk("addr",  int'(WR_ADDR),        m_bin);
    chk("ptr",   int'(WR_PTR),         gray(m_bin));
    chk("ptrp1", int'(WR_PTR_P1),      gray((m_bin + 1) % 8));
    chk("full",  int'(WR_FULL),        (m_age <= 1) ? 1 : 0);
    chk("count", int'(WR_COUNT),       m_cnt);
    chk("afull", int'(WR_ALMOST_FULL), (m_cnt >= 6) ? 1 : 0);
    chk("ovf",   int'(WR_OVERFLOW),    m_ov);
  endtask

  initial begin
    WR_RST = 1'b1; WR_EN = 1'b0; CMP_FULL = 1'b0; RD_PTR_SYNC = 3'd0;

    //            rst en cmp rd   addr ptr p1 full cnt af ov
    // reset dominates WR_EN and CMP_FULL
    tbl[0]  = '{1, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0,   0, 0, 1, 0, 0, 0, 0};
    // fill from empty
    tbl[2]  = '{0, 1, 0, 0,   1, 1, 3, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0,   2, 3, 2, 0, 2, 0, 0};
    tbl[4]  = '{0, 1, 0, 0,   3, 2, 6, 0, 3, 0, 0};
    tbl[5]  = '{0, 1, 0, 0,   4, 6, 7, 0, 4, 0, 0};
    tbl[6]  = '{0, 1, 0, 0,   5, 7, 5, 0, 5, 0, 0};
    tbl[7]  = '{0, 1, 0, 0,   6, 5, 4, 0, 6, 1, 0};
    // CMP_FULL with a write: blocked, overflow, full
    tbl[8]  = '{0, 1, 1, 0,   6, 5, 4, 1, 8, 1, 1};
    // release takes two edges, writes still dropped meanwhile
    tbl[9]  = '{0, 1, 0, 0,   6, 5, 4, 1, 8, 1, 1};
    tbl[10] = '{0, 1, 0, 0,   6, 5, 4, 0, 6, 1, 1};
    tbl[11] = '{0, 1, 0, 0,   7, 4, 0, 0, 7, 1, 0};
    // wrap with read pointer at binary 4
    tbl[12] = '{0, 1, 0, 6,   0, 0, 1, 0, 4, 0, 0};
    // five writes then reset mid-fill
    tbl[13] = '{0, 1, 0, 6,   1, 1, 3, 0, 5, 0, 0};
    tbl[14] = '{0, 1, 0, 6,   2, 3, 2, 0, 6, 1, 0};
    tbl[15] = '{0, 1, 0, 6,   3, 2, 6, 0, 7, 1, 0};
    tbl[16] = '{0, 1, 0, 6,   4, 6, 7, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 0, 6,   5, 7, 5, 0, 1, 0, 0};
    tbl[18] = '{1, 1, 0, 6,   0, 0, 1, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0,   1, 1, 3, 0, 1, 0, 0};
    // CMP_FULL glitch 1,0,1,0,0
    tbl[20] = '{0, 0, 1, 0,   1, 1, 3, 1, 8, 1, 0};
    tbl[21] = '{0, 0, 0, 0,   1, 1, 3, 1, 8, 1, 0};
    tbl[22] = '{0, 0, 1, 0,   1, 1, 3, 1, 8, 1, 0};
    tbl[23] = '{0, 0, 0, 0,   1, 1, 3, 1, 8, 1, 0};
    tbl[24] = '{0, 0, 0, 0,   1, 1, 3, 0, 1, 0, 0};

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].cmp, tbl[i].rd);
      chk($sformatf("t%0d.addr", i),  int'(WR_ADDR),        tbl[i].addr);
      chk($sformatf("t%0d.ptr", i),   int'(WR_PTR),         tbl[i].ptr);
      chk($sformatf("t%0d.ptrp1", i), int'(WR_PTR_P1),      tbl[i].p1);
      chk($sformatf("t%0d.full", i),  int'(WR_FULL),        tbl[i].full);
      chk($sformatf("t%0d.count", i), int'(WR_COUNT),       tbl[i].cnt);
      chk($sformatf("t%0d.afull", i), int'(WR_ALMOST_FULL), tbl[i].af);
      chk($sformatf("t%0d.ovf", i),   int'(WR_OVERFLOW),    tbl[i].ov);
    end

    // Randomized phase: rare resets, occasional CMP_FULL bursts, arbitrary read pointer
    step(1, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      int r_rst, r_en, r_cmp, r_rd;
      r_rst = ($urandom_range(0, 99) < 2)  ? 1 : 0;
      r_en  = ($urandom_range(0, 99) < 75) ? 1 : 0;
      r_cmp = ($urandom_range(0, 99) < 12) ? 1 : 0;
      r_rd  = gray(int'($urandom_range(0, 7)));
      step(r_rst, r_en, r_cmp, r_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
